// File: rtl/ripple_add_16_pkg.sv
// Shared constants for the ripple-carry adder/subtractor.
// WIDTH is the default operand width; RESULT_W also counts the carry out of the top bit.
package ripple_add_16_pkg;

   localparam int WIDTH    = 16;
   localparam int RESULT_W = WIDTH + 1;

endpackage : ripple_add_16_pkg

// File: rtl/ripple_add_16_full_adder.sv
// One-bit full adder cell.
// The top module chains WIDTH of these cells to form the ripple carry path.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_add_16.sv
// Ripple-carry adder/subtractor with one registered output stage and asynchronous reset.
// Defining RIPPLE_ADD_OVF_EN adds the registered signed-overflow output ovf.
module ripple_add_16
   import ripple_add_16_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         sub,
   input  logic         in_valid,
   output logic [W-1:0] sum,
   output logic         Cout,
   output logic         out_valid
`ifdef RIPPLE_ADD_OVF_EN
   ,
   output logic         ovf
`endif
);

   logic [W-1:0] b_inv;
   logic [W-1:0] result;
   logic [W:0]   carry;

   logic [W-1:0] sum_d, sum_q;
   logic         cout_d, cout_q;
   logic         out_valid_d, out_valid_q;

   // Subtraction is A + ~B + 1: invert B and inject sub as the carry-in.
   assign b_inv    = B ^ {W{sub}};
   assign carry[0] = sub;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_chain
         full_adder u_fa (
            .a    (A[gi]),
            .b    (b_inv[gi]),
            .cin  (carry[gi]),
            .s    (result[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   always_comb begin
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d  = result;
         cout_d = carry[W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign Cout      = cout_q;
   assign out_valid = out_valid_q;

`ifdef RIPPLE_ADD_OVF_EN
   logic ovf_d, ovf_q;

   // Two's-complement overflow: the carry into the sign bit differs from the carry out of it.
   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) begin
         ovf_d = carry[W] ^ carry[W-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule : ripple_add_16

// File: tb/tb_ripple_add_16.sv
// Directed testbench for ripple_add_16: add/sub vectors, idle hold, and asynchronous reset.
// Defining RIPPLE_ADD_OVF_EN also checks the ovf output.
module tb_ripple_add_16;
   import ripple_add_16_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [WIDTH-1:0]    A = '0;
   logic [WIDTH-1:0]    B = '0;
   logic                sub = 1'b0;
   logic                in_valid = 1'b0;
   logic [WIDTH-1:0]    sum;
   logic                Cout;
   logic                out_valid;
`ifdef RIPPLE_ADD_OVF_EN
   logic                ovf;
`endif

   int checks = 0;
   int errors = 0;

   ripple_add_16 dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .sub       (sub),
      .in_valid  (in_valid),
      .sum       (sum),
      .Cout      (Cout),
      .out_valid (out_valid)
`ifdef RIPPLE_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks the full output set; the expected sum is compared together with its carry bit.
   task automatic chk_out(input string tag, input logic [15:0] e_sum, input logic e_cout,
                          input logic e_valid, input logic e_ovf);
      logic [RESULT_W-1:0] obs_res;
      logic [RESULT_W-1:0] exp_res;
      obs_res = {Cout, sum};
      exp_res = {e_cout, e_sum};
      chk({tag, ".sum_cout"}, 32'(obs_res), 32'(exp_res));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
`ifdef RIPPLE_ADD_OVF_EN
      chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
`else
      if (e_ovf === 1'bx) $display("unexpected x in ovf expectation for %s", tag);
`endif
      $display("%0t %s A=%0d B=%0d sub=%0b v=%0b -> sum=%0d Cout=%0b out_valid=%0b",
               $time, tag, A, B, sub, in_valid, sum, Cout, out_valid);
   endtask

   // Apply operands at the falling edge, then sample 1 time unit after the next rising edge.
   task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic v, input logic [15:0] e_sum,
                       input logic e_cout, input logic e_valid, input logic e_ovf);
      @(negedge clk);
      A        = a;
      B        = b;
      sub      = s;
      in_valid = v;
      @(posedge clk);
      #1;
      chk_out(tag, e_sum, e_cout, e_valid, e_ovf);
   endtask

   initial begin
      // Asynchronous reset before the first clock edge, with random operands applied.
      A        = 16'($urandom);
      B        = 16'($urandom);
      sub      = 1'b0;
      in_valid = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk_out("reset_async", 16'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_out("reset_held", 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back operand pairs, one result per cycle.
      step("add_172_131", 16'd172,    16'd131, 1'b0, 1'b1, 16'd303,    1'b0, 1'b1, 1'b0);
      step("add_400_600", 16'd400,    16'd600, 1'b0, 1'b1, 16'd1000,   1'b0, 1'b1, 1'b0);
      step("add_wrap",    16'd65535,  16'd1,   1'b0, 1'b1, 16'd0,      1'b1, 1'b1, 1'b0);
      step("sub_5_3",     16'd5,      16'd3,   1'b1, 1'b1, 16'd2,      1'b1, 1'b1, 1'b0);
      step("sub_3_5",     16'd3,      16'd5,   1'b1, 1'b1, 16'd65534,  1'b0, 1'b1, 1'b0);
      step("add_ovf",     16'h7FFF,   16'h0001, 1'b0, 1'b1, 16'h8000,  1'b0, 1'b1, 1'b1);
      step("sub_ovf",     16'h8000,   16'h0001, 1'b1, 1'b1, 16'h7FFF,  1'b1, 1'b1, 1'b1);
      step("sub_equal",   16'hABCD,   16'hABCD, 1'b1, 1'b1, 16'h0000,  1'b1, 1'b1, 1'b0);

      // Idle cycles: out_valid drops, sum/Cout/ovf keep the last accepted result.
      step("idle_1",      16'd9,      16'd9,   1'b0, 1'b0, 16'h0000,   1'b1, 1'b0, 1'b0);
      step("idle_2",      16'd1,      16'd2,   1'b1, 1'b0, 16'h0000,   1'b1, 1'b0, 1'b0);
      step("add_resume",  16'd1000,   16'd24,  1'b0, 1'b1, 16'd1024,   1'b0, 1'b1, 1'b0);

      // Reset pulse mid-stream: outputs clear without an edge; operands during reset are dropped.
      @(negedge clk);
      A        = 16'd1;
      B        = 16'd1;
      sub      = 1'b0;
      in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk_out("rst_mid_async", 16'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk_out("rst_mid_held", 16'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_out("after_rst", 16'd2, 1'b0, 1'b1, 1'b0);
      step("after_rst_2", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_ripple_add_16
